// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: issues IMEM reads, tags them with PC in order, and buffers
// {PC, instr} for ID. Define IF_FETCH_PERF_EN to add the FETCH_CNT/DISCARD_CNT counters.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        CLK,
    input  logic        RSTN,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_GNT,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    input  logic        REDIRECT_EN,
    input  logic [31:0] REDIRECT_PC,
    output logic        VALID_FD,
    input  logic        READY_D,
    output logic [31:0] PC_FD,
    output logic [31:0] PC4_FD,
    output logic [31:0] IDATA_FD
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] FETCH_CNT,
    output logic [31:0] DISCARD_CNT
`endif
);

    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic          run_q;
    logic [31:0]   pc_q, pc_d;
    logic [OW-1:0] outst_q, outst_d, disc_q, disc_d;
    logic [FW:0]   cnt_q, cnt_d;
    logic [FW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [TW-1:0] twr_q, twr_d, trd_q, trd_d;
    logic [31:0]   tag_q  [MAX_OUTSTANDING];
    logic [31:0]   fpc_q  [FIFO_DEPTH];
    logic [31:0]   fdat_q [FIFO_DEPTH];
    logic          accept, rsp, drop, push, pop, empty;
    logic          unused_lsbs;

    assign unused_lsbs = ^REDIRECT_PC[1:0];

    function automatic logic [TW-1:0] tinc(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
    endfunction

    // Credit rule counts in-flight requests against free FIFO slots, so a push never overflows.
    always_comb begin
        empty     = (cnt_q == '0);
        IMEM_REQ  = run_q && !REDIRECT_EN && (outst_q < OW'(MAX_OUTSTANDING)) &&
                    ((32'(cnt_q) + 32'(outst_q)) < 32'(FIFO_DEPTH));
        IMEM_ADDR = pc_q;
        VALID_FD  = !empty && !REDIRECT_EN;
        PC_FD     = empty ? '0 : fpc_q[rd_q];
        PC4_FD    = empty ? '0 : fpc_q[rd_q] + 32'd4;
        IDATA_FD  = empty ? '0 : fdat_q[rd_q];
        accept    = IMEM_REQ && IMEM_GNT;
        rsp       = IMEM_RVALID && (outst_q != '0);
        drop      = rsp && (REDIRECT_EN || (disc_q != '0));
        push      = rsp && !drop;
        pop       = VALID_FD && READY_D;
    end

    always_comb begin
        pc_d    = pc_q;
        outst_d = outst_q;
        disc_d  = disc_q;
        cnt_d   = cnt_q;
        if (REDIRECT_EN)  pc_d = {REDIRECT_PC[31:2], 2'b00};
        else if (accept)  pc_d = pc_q + 32'd4;
        if (accept && !rsp)      outst_d = outst_q + OW'(1);
        else if (!accept && rsp) outst_d = outst_q - OW'(1);
        // Everything still in flight after a redirect belongs to the old path.
        if (REDIRECT_EN)                 disc_d = outst_d;
        else if (rsp && disc_q != '0)    disc_d = disc_q - OW'(1);
        if (REDIRECT_EN)         cnt_d = '0;
        else if (push && !pop)   cnt_d = cnt_q + (FW+1)'(1);
        else if (!push && pop)   cnt_d = cnt_q - (FW+1)'(1);
        wr_d  = push ? wr_q + FW'(1) : wr_q;
        rd_d  = REDIRECT_EN ? wr_q : (pop ? rd_q + FW'(1) : rd_q);
        twr_d = accept ? tinc(twr_q) : twr_q;
        trd_d = rsp ? tinc(trd_q) : trd_q;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            run_q   <= 1'b0;
            pc_q    <= RESET_PC;
            outst_q <= '0;
            disc_q  <= '0;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            twr_q   <= '0;
            trd_q   <= '0;
        end else begin
            run_q   <= 1'b1;
            pc_q    <= pc_d;
            outst_q <= outst_d;
            disc_q  <= disc_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            twr_q   <= twr_d;
            trd_q   <= trd_d;
        end
    end

    // Storage needs no reset: contents are only observed while cnt_q says they are valid.
    always_ff @(posedge CLK) begin
        if (accept) tag_q[twr_q] <= pc_q;
        if (push) begin
            fpc_q[wr_q]  <= tag_q[trd_q];
            fdat_q[wr_q] <= IMEM_RDATA;
        end
    end

`ifdef IF_FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d, disc_cnt_q, disc_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + 32'(pop);
        disc_cnt_d  = disc_cnt_q + 32'(drop);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            fetch_cnt_q <= '0;
            disc_cnt_q  <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            disc_cnt_q  <= disc_cnt_d;
        end
    end

    assign FETCH_CNT   = fetch_cnt_q;
    assign DISCARD_CNT = disc_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, hand-written reset/backpressure
// sequences and a randomized run checked against a queue-based transaction model.
module tb_if_fetch_unit;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        IMEM_GNT, IMEM_RVALID, REDIRECT_EN, READY_D;
    logic [31:0] IMEM_RDATA, REDIRECT_PC;
    logic        req, valid, w_req, w_valid;
    logic [31:0] addr, pc, pc4, idata, w_addr, w_pc, w_pc4, w_idata;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] fcnt, dcnt, w_fcnt, w_dcnt;
`endif

    always #5 CLK = ~CLK;

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .CLK(CLK), .RSTN(RSTN), .IMEM_REQ(req), .IMEM_ADDR(addr), .IMEM_GNT(IMEM_GNT),
        .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA), .REDIRECT_EN(REDIRECT_EN),
        .REDIRECT_PC(REDIRECT_PC), .VALID_FD(valid), .READY_D(READY_D), .PC_FD(pc),
        .PC4_FD(pc4), .IDATA_FD(idata)
`ifdef IF_FETCH_PERF_EN
        , .FETCH_CNT(fcnt), .DISCARD_CNT(dcnt)
`endif
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut_w (
        .CLK(CLK), .RSTN(RSTN), .IMEM_REQ(w_req), .IMEM_ADDR(w_addr), .IMEM_GNT(IMEM_GNT),
        .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA), .REDIRECT_EN(REDIRECT_EN),
        .REDIRECT_PC(REDIRECT_PC), .VALID_FD(w_valid), .READY_D(READY_D), .PC_FD(w_pc),
        .PC4_FD(w_pc4), .IDATA_FD(w_idata)
`ifdef IF_FETCH_PERF_EN
        , .FETCH_CNT(w_fcnt), .DISCARD_CNT(w_dcnt)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    // Transaction model: next fetch address, in-flight tags, buffered PCs, discard budget.
    logic [31:0] m_pc;
    int          m_out, m_disc;
    logic [31:0] m_fifo[$];
    logic [31:0] m_tags[$];
    logic [31:0] pend[$];
    logic [31:0] m_fetch, m_drop;

    typedef struct {
        logic        g, rv;
        logic [31:0] ra;
        logic        rdy, rdr;
        logic [31:0] rpc;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evld;
        logic [31:0] epc;
    } vec_t;
    vec_t tbl[15];

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'h5A5A_1234;
    endfunction

    function automatic vec_t mk(input logic g, rv, input logic [31:0] ra, input logic rdy, rdr,
                                input logic [31:0] rpc, input logic ereq, input logic [31:0] eaddr,
                                input logic evld, input logic [31:0] epc);
        vec_t v;
        v.g = g; v.rv = rv; v.ra = ra; v.rdy = rdy; v.rdr = rdr; v.rpc = rpc;
        v.ereq = ereq; v.eaddr = eaddr; v.evld = evld; v.epc = epc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_out = 0; m_disc = 0;
        m_fifo.delete(); m_tags.delete(); pend.delete();
        m_fetch = 0; m_drop = 0;
    endtask

    // Called between edges with inputs stable: compare, then advance to the next edge.
    task automatic model_step();
        logic ereq, evld, acc, popd;
        logic [31:0] tag;
        ereq = !REDIRECT_EN && (m_out < MAXO) && ((m_fifo.size() + m_out) < DEPTH);
        chkb("imem_req", req, ereq);
        if (ereq) chk("imem_addr", addr, m_pc);
        evld = (m_fifo.size() > 0) && !REDIRECT_EN;
        chkb("valid_fd", valid, evld);
        if (evld) begin
            chk("pc_fd", pc, m_fifo[0]);
            chk("pc4_fd", pc4, m_fifo[0] + 32'd4);
            chk("idata_fd", idata, dat(m_fifo[0]));
        end
`ifdef IF_FETCH_PERF_EN
        chk("fetch_cnt", fcnt, m_fetch);
        chk("discard_cnt", dcnt, m_drop);
`endif
        acc  = ereq && IMEM_GNT;
        popd = evld && READY_D;
        if (popd) begin
            void'(m_fifo.pop_front());
            m_fetch++;
        end
        if (IMEM_RVALID && m_tags.size() > 0) begin
            tag = m_tags.pop_front();
            m_out--;
            if (REDIRECT_EN || m_disc > 0) begin
                if (!REDIRECT_EN) m_disc--;
                m_drop++;
            end else begin
                m_fifo.push_back(tag);
            end
        end
        if (acc) begin
            m_tags.push_back(m_pc);
            m_pc += 32'd4;
            m_out++;
        end
        if (REDIRECT_EN) begin
            m_fifo.delete();
            m_pc   = REDIRECT_PC & ~32'd3;
            m_disc = m_out;
        end
        if (IMEM_RVALID && pend.size() > 0) void'(pend.pop_front());
        if (req && IMEM_GNT) pend.push_back(addr);
    endtask

    task automatic apply(input logic g, rv, input logic [31:0] rd, input logic rdy, rdr,
                         input logic [31:0] rpc);
        @(posedge CLK); #1;
        IMEM_GNT = g; IMEM_RVALID = rv; IMEM_RDATA = rd;
        READY_D = rdy; REDIRECT_EN = rdr; REDIRECT_PC = rpc;
        @(negedge CLK);
        model_step();
    endtask

    task automatic apply_auto(input int pg, pr, prdy, prd);
        logic g, rv, rdy, rdr;
        logic [31:0] rd;
        g   = int'($urandom_range(0, 99)) < pg;
        rv  = (pend.size() > 0) && (int'($urandom_range(0, 99)) < pr);
        rd  = rv ? dat(pend[0]) : 32'h0;
        rdy = int'($urandom_range(0, 99)) < prdy;
        rdr = int'($urandom_range(0, 99)) < prd;
        apply(g, rv, rd, rdy, rdr, $urandom);
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RSTN = 1'b0;
        IMEM_GNT = 0; IMEM_RVALID = 0; IMEM_RDATA = 0;
        READY_D = 0; REDIRECT_EN = 0; REDIRECT_PC = 0;
        #1;
        chkb("rst_req", req, 1'b0);
        chkb("rst_valid", valid, 1'b0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc4", pc4, 32'h0);
        chk("rst_idata", idata, 32'h0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;
        model_reset();
        #1;
        chkb("req_at_release", req, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        RSTN = 1'b0;
        IMEM_GNT = 0; IMEM_RVALID = 0; IMEM_RDATA = 0;
        READY_D = 0; REDIRECT_EN = 0; REDIRECT_PC = 0;

        // Stream, GNT stall, redirect with two responses in flight, restart at 0x100.
        tbl[0]  = mk(1, 0, 0,         1, 0, 0,     1, 32'h000, 0, 0);
        tbl[1]  = mk(1, 1, 32'h000,   1, 0, 0,     1, 32'h004, 0, 0);
        tbl[2]  = mk(1, 1, 32'h004,   1, 0, 0,     1, 32'h008, 1, 32'h000);
        tbl[3]  = mk(1, 1, 32'h008,   1, 0, 0,     1, 32'h00C, 1, 32'h004);
        tbl[4]  = mk(1, 0, 0,         1, 0, 0,     1, 32'h010, 1, 32'h008);
        tbl[5]  = mk(1, 1, 32'h00C,   1, 0, 0,     0, 0,       0, 0);
        tbl[6]  = mk(1, 0, 0,         1, 0, 0,     1, 32'h014, 1, 32'h00C);
        tbl[7]  = mk(1, 1, 32'h010,   1, 1, 32'h103, 0, 0,     0, 0);
        tbl[8]  = mk(1, 1, 32'h014,   1, 0, 0,     1, 32'h100, 0, 0);
        tbl[9]  = mk(0, 1, 32'h100,   1, 0, 0,     1, 32'h104, 0, 0);
        tbl[10] = mk(0, 0, 0,         1, 0, 0,     1, 32'h104, 1, 32'h100);
        tbl[11] = mk(0, 0, 0,         1, 0, 0,     1, 32'h104, 0, 0);
        tbl[12] = mk(1, 0, 0,         1, 0, 0,     1, 32'h104, 0, 0);
        tbl[13] = mk(0, 1, 32'h104,   1, 0, 0,     1, 32'h108, 0, 0);
        tbl[14] = mk(0, 0, 0,         1, 0, 0,     1, 32'h108, 1, 32'h104);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            apply(tbl[i].g, tbl[i].rv, tbl[i].rv ? dat(tbl[i].ra) : 32'h0,
                  tbl[i].rdy, tbl[i].rdr, tbl[i].rpc);
            chkb($sformatf("tbl%0d_req", i), req, tbl[i].ereq);
            if (tbl[i].ereq) chk($sformatf("tbl%0d_addr", i), addr, tbl[i].eaddr);
            chkb($sformatf("tbl%0d_valid", i), valid, tbl[i].evld);
            if (tbl[i].evld) begin
                chk($sformatf("tbl%0d_pc", i), pc, tbl[i].epc);
                chk($sformatf("tbl%0d_pc4", i), pc4, tbl[i].epc + 32'd4);
                chk($sformatf("tbl%0d_idata", i), idata, dat(tbl[i].epc));
            end
            case (i)
                0: chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
                1: chk("wrap_addr1", w_addr, 32'h0000_0000);
                2: begin
                    chkb("wrap_valid", w_valid, 1'b1);
                    chk("wrap_pc0", w_pc, 32'hFFFF_FFFC);
                    chk("wrap_pc4_0", w_pc4, 32'h0000_0000);
                end
                3: begin
                    chk("wrap_pc1", w_pc, 32'h0000_0000);
                    chk("wrap_pc4_1", w_pc4, 32'h0000_0004);
                end
                default: ;
            endcase
        end

        // Backpressure: four entries buffered, fetch stalls, then drain in order.
        do_reset();
        repeat (10) apply_auto(100, 100, 0, 0);
        chkb("bp_req_stalled", req, 1'b0);
        chkb("bp_valid", valid, 1'b1);
        for (int k = 0; k < 4; k++) begin
            apply_auto(100, 100, 100, 0);
            chk($sformatf("bp_drain%0d", k), pc, 32'(k * 4));
        end

        // Reset mid-stream with two requests outstanding and entries buffered.
        do_reset();
        repeat (3) apply_auto(100, 100, 0, 0);
        repeat (2) apply_auto(100, 0, 0, 0);
        chkb("mid_valid_pre", valid, 1'b1);
        chk("mid_wpc_pre", w_pc, 32'hFFFF_FFFC);
        #2;
        RSTN = 1'b0;
        IMEM_RVALID = 1'b1;
        IMEM_RDATA = dat(32'h8);
        #1;
        chkb("mid_req", req, 1'b0);
        chkb("mid_valid", valid, 1'b0);
        chk("mid_pc", pc, 32'h0);
        chk("mid_pc4", pc4, 32'h0);
        chk("mid_idata", idata, 32'h0);
        chk("mid_wpc", w_pc, 32'h0);
        chk("mid_wpc4", w_pc4, 32'h0);
`ifdef IF_FETCH_PERF_EN
        chk("mid_fcnt", fcnt, 32'h0);
        chk("mid_dcnt", dcnt, 32'h0);
`endif
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;
        IMEM_RVALID = 1'b0;
        model_reset();
        #1;
        chkb("mid_req_release", req, 1'b0);
        apply_auto(100, 100, 100, 0);
        chk("mid_restart_addr", addr, 32'h0);
        repeat (4) apply_auto(100, 100, 100, 0);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) apply_auto(70, 60, 70, 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
